// File: rtl/avg_reg_pkg.sv
// Shared types for the averaging duty regulator: FSM states and channel-select encodings.
package avg_reg_pkg;
  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    DISCARD = 2'd1,
    ACCUM   = 2'd2,
    DECIDE  = 2'd3
  } state_t;

  localparam logic MODE_CV = 1'b0;
  localparam logic MODE_CC = 1'b1;
endpackage

// File: rtl/avg_accum.sv
// Power-of-two window accumulator: sums 2^LOG2_N samples, flags the Nth add combinationally.
// Clear has priority over add; the sum is sized so a full window cannot overflow.
module avg_accum #(
  parameter int W      = 12,
  parameter int LOG2_N = 2
) (
  input  logic                clk,
  input  logic                i_clear,
  input  logic                i_add,
  input  logic [W-1:0]        i_sample,
  output logic [W+LOG2_N-1:0] o_sum,
  output logic [W-1:0]        o_avg,
  output logic                o_count_done
);
  localparam int N     = 1 << LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int SW    = W + LOG2_N;

  logic [SW-1:0]    r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + SW'(i_sample);
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_sum        = r_sum;
  assign o_avg        = W'(r_sum >> LOG2_N);
  assign o_count_done = i_add && w_last;
endmodule

// File: rtl/avg_duty_regulator.sv
// CC/CV averaging regulator: averages a window of the selected ADC channel and steps the
// PWM on-time toward the window with saturation. All outputs registered, updated at the end of DECIDE.
module avg_duty_regulator
  import avg_reg_pkg::*;
#(
  parameter int W           = 12,
  parameter int LOG2_N      = 2,
  parameter int DISCARD_N   = 1,
  parameter int WAIT_CYCLES = 50,
  parameter int TON_W       = 10,
  parameter int TON_INIT    = 288,
  parameter int TON_MIN     = 0,
  parameter int TON_MAX     = 460,
  parameter int STEP        = 1
) (
  input  logic             clk_1M,
  input  logic             rst,
  input  logic             mode,
  input  logic             sample_valid,
  input  logic [W-1:0]     v_sample,
  input  logic [W-1:0]     i_sample,
  input  logic [W-1:0]     v_min_in,
  input  logic [W-1:0]     v_max_in,
  input  logic [W-1:0]     i_min_in,
  input  logic [W-1:0]     i_max_in,
  output logic [W-1:0]     avg_out,
  output logic             avg_valid,
  output logic [TON_W-1:0] time_on,
  output logic             in_window,
  output logic             at_limit
);
  localparam int N    = 1 << LOG2_N;
  localparam int SW   = W + LOG2_N;
  localparam int WC_W = $clog2(WAIT_CYCLES + 2);
  localparam int DC_W = $clog2(DISCARD_N + 2);
  localparam int CW   = TON_W + 2;
  localparam state_t START_ST = (DISCARD_N == 0) ? ACCUM : DISCARD;
  localparam logic [TON_W-1:0] TON_INIT_V = TON_W'(TON_INIT);
  localparam logic [TON_W-1:0] TON_MIN_V  = TON_W'(TON_MIN);
  localparam logic [TON_W-1:0] TON_MAX_V  = TON_W'(TON_MAX);
  localparam logic LIMIT_INIT = (TON_INIT == TON_MIN) || (TON_INIT == TON_MAX);

  state_t           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [DC_W-1:0]  r_disc_cnt;
  logic             r_mode;
  logic [W-1:0]     r_avg_out;
  logic             r_avg_valid;
  logic [TON_W-1:0] r_time_on;
  logic             r_in_window;
  logic             r_at_limit;

  logic             w_abort, w_add, w_clear, w_done;
  logic [W-1:0]     w_sample, w_lo, w_hi, w_avg;
  logic [SW-1:0]    w_sum, w_lo_sum, w_hi_sum;
  logic [CW-1:0]    w_ton_ext, w_up;
  logic [TON_W-1:0] w_dn, w_ton_up, w_ton_dn, w_ton_next;
  logic             w_in_win;

  // Window data and thresholds follow the mode latched at window start.
  assign w_sample = (r_mode == MODE_CC) ? i_sample : v_sample;
  assign w_lo     = (r_mode == MODE_CC) ? i_min_in : v_min_in;
  assign w_hi     = (r_mode == MODE_CC) ? i_max_in : v_max_in;

  assign w_abort = ((r_state == DISCARD) || (r_state == ACCUM)) && (mode != r_mode);
  assign w_add   = (r_state == ACCUM) && sample_valid && !w_abort;
  assign w_clear = rst || (r_state != ACCUM) || w_abort;

  avg_accum #(.W(W), .LOG2_N(LOG2_N)) u_accum (
    .clk          (clk_1M),
    .i_clear      (w_clear),
    .i_add        (w_add),
    .i_sample     (w_sample),
    .o_sum        (w_sum),
    .o_avg        (w_avg),
    .o_count_done (w_done)
  );

  // Comparing the full sum against scaled bounds is exact for the truncated average.
  assign w_lo_sum = SW'(w_lo) << LOG2_N;
  assign w_hi_sum = (SW'(w_hi) << LOG2_N) | SW'(N - 1);

  assign w_ton_ext = CW'(r_time_on);
  assign w_up      = w_ton_ext + CW'(STEP);
  assign w_dn      = r_time_on - TON_W'(STEP);
  assign w_ton_up  = (w_up > CW'(TON_MAX)) ? TON_MAX_V : w_up[TON_W-1:0];
  assign w_ton_dn  = (w_ton_ext < (CW'(TON_MIN) + CW'(STEP))) ? TON_MIN_V : w_dn;

  always_comb begin
    w_ton_next = r_time_on;
    w_in_win   = 1'b0;
    if (w_lo > w_hi) begin
      w_ton_next = r_time_on;
    end else if (w_sum < w_lo_sum) begin
      w_ton_next = w_ton_up;
    end else if (w_sum > w_hi_sum) begin
      w_ton_next = w_ton_dn;
    end else begin
      w_in_win = 1'b1;
    end
  end

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      r_state     <= WAIT;
      r_wait_cnt  <= '0;
      r_disc_cnt  <= '0;
      r_mode      <= MODE_CV;
      r_avg_out   <= '0;
      r_avg_valid <= 1'b0;
      r_time_on   <= TON_INIT_V;
      r_in_window <= 1'b0;
      r_at_limit  <= LIMIT_INIT;
    end else begin
      r_avg_valid <= 1'b0;
      case (r_state)
        WAIT: begin
          if ((WAIT_CYCLES == 0) || (r_wait_cnt == WC_W'(WAIT_CYCLES - 1))) begin
            r_wait_cnt <= '0;
            r_mode     <= mode;
            r_state    <= START_ST;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        DISCARD: begin
          if (w_abort) begin
            r_disc_cnt <= '0;
            r_mode     <= mode;
            r_state    <= START_ST;
          end else if (sample_valid) begin
            if (r_disc_cnt == DC_W'(DISCARD_N - 1)) begin
              r_disc_cnt <= '0;
              r_state    <= ACCUM;
            end else begin
              r_disc_cnt <= r_disc_cnt + DC_W'(1);
            end
          end
        end
        ACCUM: begin
          if (w_abort) begin
            r_mode  <= mode;
            r_state <= START_ST;
          end else if (w_done) begin
            r_state <= DECIDE;
          end
        end
        DECIDE: begin
          r_avg_out   <= w_avg;
          r_time_on   <= w_ton_next;
          r_in_window <= w_in_win;
          r_at_limit  <= (w_ton_next == TON_MIN_V) || (w_ton_next == TON_MAX_V);
          r_avg_valid <= 1'b1;
          r_disc_cnt  <= '0;
          r_mode      <= mode;
          r_state     <= START_ST;
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  assign avg_out   = r_avg_out;
  assign avg_valid = r_avg_valid;
  assign time_on   = r_time_on;
  assign in_window = r_in_window;
  assign at_limit  = r_at_limit;
endmodule
